// File: rtl/uart_bus_pkg.sv
// Shared types and constants for the UART host memory-bus blocks.
package uart_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } bus_state_t;

  localparam logic [15:0] ERR_DATA_DEFAULT = 16'hDEAD;

endpackage

// File: rtl/uart_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after rr_ptr,
// searching cyclically; returns one-hot and binary index.
module rr_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDX_W'((32'(rr_ptr) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/uart_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus port among NUM_MST requesters,
// one outstanding transaction, with a bounded read-response timeout.
module uart_bus_arbiter
  import uart_bus_pkg::*;
#(
  parameter int unsigned       NUM_MST      = 2,
  parameter int unsigned       ADDR_W       = 16,
  parameter int unsigned       DATA_W       = 16,
  parameter int unsigned       RESP_TIMEOUT = 255,
  parameter logic [DATA_W-1:0] ERR_DATA     = DATA_W'(ERR_DATA_DEFAULT)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_MST*ADDR_W-1:0]   m_address,
  input  logic [NUM_MST-1:0]          m_wvalid,
  input  logic [NUM_MST*DATA_W-1:0]   m_wdata,
  output logic [NUM_MST-1:0]          m_wready,
  input  logic [NUM_MST-1:0]          m_rvalid,
  output logic [NUM_MST-1:0]          m_rready,
  output logic [NUM_MST-1:0]          m_rrvalid,
  output logic [NUM_MST*DATA_W-1:0]   m_rdata,
  output logic [ADDR_W-1:0]           s_address,
  output logic                        s_wvalid,
  output logic [DATA_W-1:0]           s_wdata,
  output logic                        s_rvalid,
  input  logic                        s_wready,
  input  logic                        s_rready,
  input  logic                        s_rrvalid,
  input  logic [DATA_W-1:0]           s_rdata,
  output logic [NUM_MST-1:0]          grant,
  output logic                        timeout_err
);

  localparam int unsigned IDX_W  = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
  localparam int unsigned TCNT_W = $clog2(RESP_TIMEOUT + 1);

  bus_state_t          state, state_d;
  logic [NUM_MST-1:0]  grant_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [NUM_MST-1:0]  req, pick_oh;
  logic [IDX_W-1:0]    pick_idx;
  logic                g_wvalid, g_rvalid;
  logic [DATA_W-1:0]   rdata_c;

  logic [ADDR_W-1:0]   addr_a  [NUM_MST];
  logic [DATA_W-1:0]   wdata_a [NUM_MST];

  // Unflatten master-side buses so the granted index can select directly.
  for (genvar i = 0; i < NUM_MST; i++) begin : g_unpack
    assign addr_a[i]  = m_address[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = m_wdata[i*DATA_W +: DATA_W];
  end

  assign req = m_wvalid | m_rvalid;

  rr_pick #(
    .N     (NUM_MST),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .gnt    (pick_oh),
    .idx    (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      grant    <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      tcnt_q   <= '0;
    end else begin
      state    <= state_d;
      grant    <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      tcnt_q   <= tcnt_d;
    end
  end

  always_comb begin
    state_d     = state;
    grant_d     = grant;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    tcnt_d      = tcnt_q;
    s_address   = '0;
    s_wdata     = '0;
    s_wvalid    = 1'b0;
    s_rvalid    = 1'b0;
    m_wready    = '0;
    m_rready    = '0;
    m_rrvalid   = '0;
    rdata_c     = '0;
    timeout_err = 1'b0;
    g_wvalid    = m_wvalid[gidx_q];
    g_rvalid    = m_rvalid[gidx_q];

    unique case (state)
      ST_IDLE: begin
        if (|req) begin
          state_d  = ST_REQ;
          grant_d  = pick_oh;
          gidx_d   = pick_idx;
          rr_ptr_d = (pick_idx == IDX_W'(NUM_MST - 1)) ? '0 : pick_idx + IDX_W'(1);
        end
      end

      ST_REQ: begin
        s_address = addr_a[gidx_q];
        s_wdata   = wdata_a[gidx_q];
        s_wvalid  = g_wvalid;
        // Write takes priority when a master raises both valids.
        s_rvalid  = g_rvalid & ~g_wvalid;
        m_wready[gidx_q] = s_wready & s_wvalid;
        m_rready[gidx_q] = s_rready & s_rvalid;
        if (s_wvalid && s_wready) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else if (s_rvalid && s_rready) begin
          state_d = ST_RESP;
          tcnt_d  = '0;
        end else if (!g_wvalid && !g_rvalid) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end

      ST_RESP: begin
        if (tcnt_q != '1) tcnt_d = tcnt_q + TCNT_W'(1);
        // A real response on the last allowed cycle still wins over the timeout.
        if (s_rrvalid) begin
          m_rrvalid[gidx_q] = 1'b1;
          rdata_c           = s_rdata;
          state_d           = ST_IDLE;
          grant_d           = '0;
        end else if (tcnt_q == TCNT_W'(RESP_TIMEOUT - 1)) begin
          m_rrvalid[gidx_q] = 1'b1;
          rdata_c           = ERR_DATA;
          timeout_err       = 1'b1;
          state_d           = ST_IDLE;
          grant_d           = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign m_rdata = {NUM_MST{rdata_c}};

endmodule

// File: doc/uart_bus_arbiter.md
# uart_bus_arbiter

Round-robin arbiter sharing one on-chip memory bus port between `NUM_MST` requesters, with master 0 the UART host bus and the others on-chip logic. It uses the UART host's handshake on both sides: valid/ready request, then a later `rrvalid` read response. It allows one outstanding transaction and bounds read latency with a response timeout, so a dead slave cannot hang the UART link.

## Interface
Parameters:
- `NUM_MST`, default 2: number of requesters, 2..8.
- `ADDR_W`, default 16: address width.
- `DATA_W`, default 16: data width.
- `RESP_TIMEOUT`, default 255: number of cycles in RESP before a synthetic read response; 1..65535.
- `ERR_DATA`, default `'hDEAD` (truncated to `DATA_W`): rdata returned on timeout.

Ports (master-side vectors are flattened; master i occupies slice [i*W +: W]):
- `clk`  in  1  clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `m_address`  in  NUM_MST*ADDR_W  per-master address.
- `m_wvalid`  in  NUM_MST  per-master write request.
- `m_wdata`  in  NUM_MST*DATA_W  per-master write data.
- `m_wready`  out  NUM_MST  write accept, granted master only.
- `m_rvalid`  in  NUM_MST  per-master read request.
- `m_rready`  out  NUM_MST  read accept, granted master only.
- `m_rrvalid`  out  NUM_MST  read response valid, granted master only.
- `m_rdata`  out  NUM_MST*DATA_W  read data, broadcast to all masters; qualified by `m_rrvalid`.
- `s_address`, `s_wvalid`, `s_wdata`, `s_rvalid`  out  ADDR_W / 1 / DATA_W / 1  slave request.
- `s_wready`, `s_rready`, `s_rrvalid`, `s_rdata`  in  1 / 1 / 1 / DATA_W  slave response.
- `grant`  out  NUM_MST  one-hot current owner; 0 in IDLE.
- `timeout_err`  out  1  one-cycle pulse when a read times out.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: `req[i] = m_wvalid[i] | m_rvalid[i]`. If any bit of `req` is set, register a one-hot `grant` for the first requester at or after `rr_ptr` (cyclic search) and go to REQ.
- REQ, forwarding: `s_address` and `s_wdata` come from the granted master. `s_wvalid = m_wvalid[g]`. `s_rvalid = m_rvalid[g] & ~m_wvalid[g]`, so write wins if a master asserts both.
- REQ, ready routing: `m_wready[g] = s_wready & s_wvalid`; `m_rready[g] = s_rready & s_rvalid`. All other readies are 0.
- REQ, write handshake: go to IDLE.
- REQ, read handshake: go to RESP and clear `tcnt`.
- REQ, request dropped: if the granted master's valids are both low, go to IDLE with no slave transfer.
- RESP: `s_*valid` are 0. `m_rrvalid[g] = s_rrvalid` and `m_rdata = s_rdata`; go to IDLE on `s_rrvalid`. `tcnt` increments each cycle.
- RESP timeout: when `tcnt == RESP_TIMEOUT-1` with no `s_rrvalid`, drive `m_rrvalid[g]=1` and `m_rdata=ERR_DATA` combinationally for that cycle, pulse `timeout_err`, and go to IDLE.
- RESP, late response: an `s_rrvalid` arriving after the timeout is ignored.
- `rr_ptr` updates to (granted index + 1) mod `NUM_MST` on each IDLE→REQ transition.
- Async reset (any state, including mid-transaction): state=IDLE, `grant`=0, `rr_ptr`=0, `tcnt`=0. All outputs are then 0 (`s_address`, `s_wdata` and `m_rdata` are don't-care; bench expects 0).

## Timing
- Arbitration latency: 1 cycle. A request in IDLE at cycle N appears on `s_*` at N+1.
- Minimum transaction lengths: write 2 cycles (IDLE, REQ) when `s_wready` is already high; read 3 cycles plus slave latency.
- Back-to-back: after the IDLE return there is one IDLE cycle before the next grant, so fairness is exact (A, B, A, B with both masters permanently requesting).
- Slave request and all master-side outputs are combinational from registered `grant`/state plus inputs; there are no extra pipeline registers.
- `tcnt` is `$clog2(RESP_TIMEOUT+1)` bits wide and saturates.

## Structure
- Package `uart_bus_pkg`: state enum (IDLE/REQ/RESP) and the default `ERR_DATA` constant, shared with future bus blocks.
- One sub-module: `rr_pick`, combinational round-robin one-hot selector (inputs `req`, `rr_ptr`; output one-hot plus index).

## Test plan
- Single write: M0 wvalid, addr 0x0010, wdata 0x1234, `s_wready`=1 → `s_wvalid` at cycle+1 with 0x0010/0x1234; `m_wready[0]` pulses; back to IDLE.
- Single read: M1 rvalid addr 0x0020; slave returns 0xBEEF 4 cycles after `s_rready` → `m_rrvalid[1]` with 0xBEEF; `m_rrvalid[0]` stays 0.
- Contention: M0 and M1 request continuously from reset → grants M0, M1, M0, M1; `rr_ptr` alternates 1, 0.
- Timeout with `RESP_TIMEOUT`=8: read with no `s_rrvalid` → on the 8th RESP cycle `m_rrvalid`=1, data 0xDEAD, `timeout_err` pulses; a later `s_rrvalid` is ignored.
- Both valids from M0 (write 0x5555 and read) → only `s_wvalid` is forwarded, `s_rvalid`=0.
- `rst_n` asserted in RESP → `grant`=0 and IDLE immediately (asynchronous); the next request is granted normally after release.
